tcb_femto_bridge: RTL
=====================

Name: tcb_femto_bridge

Overview:
- TCB responder that converts TCB load/store transfers into the FemtoRV32 native memory/IO port.
- Lets existing FemtoRV-style peripherals and memories hang off a TCB decoder port. It is the far end of the FemtoRV-to-TCB mapping used by the core benches.
- One transfer in flight at a time.
- A FemtoRV-style strobe/mask pulse is issued, device busy is honoured, and rdy is returned once the device completes.

Parameters:
- AW, 22, TCB address width; zero-extended onto mem_addr.
- TMO, 255, timeout limit in busy-wait cycles. Used only with the optional feature; legal range 1..65535.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- tcb_vld  input  1  TCB transfer valid
- tcb_wen  input  1  TCB write enable (1=write, 0=read)
- tcb_adr  input  AW  TCB byte address
- tcb_ben  input  4  TCB byte enables
- tcb_wdt  input  32  TCB write data
- tcb_rdt  output  32  TCB read data (registered)
- tcb_rdy  output  1  TCB ready; transfer completes on tcb_vld & tcb_rdy
- err  output  1  completion-with-error flag, valid with tcb_rdy
- mem_addr  output  32  device address
- mem_wdata  output  32  device write data
- mem_wmask  output  4  device write byte mask; non-zero for exactly one cycle per write
- mem_rdata  input  32  device read data
- mem_rstrb  output  1  device read strobe; one-cycle pulse per read
- mem_rbusy  input  1  device read busy
- mem_wbusy  input  1  device write busy

Behaviour:
- Reset values (registered): state=IDLE, tcb_rdy=0, err=0, tcb_rdt=0, mem_addr=0, mem_wdata=0, mem_wmask=0, mem_rstrb=0.
- Reset is honoured in any state and aborts an in-flight access. No strobe or mask is issued in the cycle after rst.
- FSM states are IDLE, STRB, WAIT, DONE.
- IDLE:
  - tcb_rdy=0.
  - On tcb_vld=1, latch the request: mem_addr={(32-AW)'0,tcb_adr}, mem_wdata=tcb_wdt, ben, wen. Go to STRB.
- STRB (exactly one cycle):
  - Write with ben!=0: mem_wmask=latched ben.
  - Write with ben==0: mem_wmask stays 0 and no device access is made. The transfer still completes through WAIT/DONE.
  - Read: mem_rstrb=1. The read strobe ignores ben.
  - Busy inputs are ignored in this cycle. Go to WAIT.
- WAIT:
  - Strobes are 0. Monitor mem_rbusy for reads and mem_wbusy for writes; the other busy is ignored.
  - While the relevant busy=1, stay in WAIT.
  - When it is 0: on a read, capture mem_rdata into tcb_rdt. Go to DONE.
- DONE (exactly one cycle):
  - tcb_rdy=1. The initiator is required to hold tcb_vld and request fields stable from IDLE acceptance through DONE.
  - Go to IDLE; a new tcb_vld is accepted there on the next cycle.
- tcb_rdt holds its value until the next read completes. Writes never alter it. It is valid in the DONE cycle and in every later cycle, which satisfies both the 0-delay and 1-delay TCB read conventions.
- Latency from tcb_vld first seen in IDLE to tcb_rdy:
  - 3 cycles with a zero-wait device.
  - 3+N cycles when busy is held for N cycles after the strobe.
  - Minimum back-to-back throughput is one transfer per 4 cycles.
- tcb_vld=0 while in STRB/WAIT is a protocol violation. The access still runs to DONE, and tcb_rdy pulses regardless.
- Without the optional feature, err is constant 0.

Optional Feature:
- Macro: TCB_FEMTO_BRIDGE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each cycle busy=1.
  - If the counter reaches TMO while busy is still 1, go to DONE with err=1. On a read, tcb_rdt is set to 32'hdeadbeef.
  - The counter resets to 0 on rst.
  - If busy drops in the same cycle the counter reaches TMO, normal completion wins and err=0.
- Undefined: no counter is built, WAIT waits indefinitely, and err is tied 0.

Test Plan:
- Reset then idle: rst high 2 cycles, tcb_vld=0 → all outputs 0 and tcb_rdy never asserted over 20 cycles.
- Zero-wait read: adr=0x000104, mem_rdata=0x12345678, busy=0 → mem_addr=0x00000104; mem_rstrb pulses 1 cycle; tcb_rdy 3 cycles after vld; tcb_rdt=0x12345678, held after completion.
- Stalled write: adr=0x000200, ben=4'b0011, wdt=0xA5A5_5A5A, mem_wbusy=1 for 4 cycles after strobe → mem_wmask=4'b0011 for exactly 1 cycle; tcb_rdy at cycle 7; tcb_rdt unchanged.
- Write with ben=0: tcb_wen=1, tcb_ben=0 → mem_wmask stays 0 throughout; tcb_rdy at cycle 3.
- Reset mid-access: read with mem_rbusy=1, assert rst during WAIT → next cycle state IDLE, tcb_rdy=0, tcb_rdt=0; a following zero-wait read returns correct data.
- Timeout (macro defined, TMO=8): read with mem_rbusy stuck 1 → tcb_rdy and err=1 at cycle 3+8, tcb_rdt=0xDEADBEEF. Repeat with busy dropping at count 8 → err=0 and real data returned.

Source files
------------

// File: rtl/tcb_femto_bridge.sv
// tcb_femto_bridge: TCB responder driving a FemtoRV32-style memory/IO port.
// One transfer in flight; IDLE -> STRB -> WAIT -> DONE -> IDLE.
// Optional busy-wait timeout: define TCB_FEMTO_BRIDGE_TIMEOUT_EN.
// Handshake: a transfer is accepted when tcb_vld is seen in IDLE and ends
// on the single DONE cycle where tcb_rdy=1; the initiator holds tcb_vld and
// the request fields stable from acceptance through DONE.
module tcb_femto_bridge #(
   parameter int unsigned AW  = 22,
   parameter int unsigned TMO = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tcb_vld,
   input  logic          tcb_wen,
   input  logic [AW-1:0] tcb_adr,
   input  logic [3:0]    tcb_ben,
   input  logic [31:0]   tcb_wdt,
   output logic [31:0]   tcb_rdt,
   output logic          tcb_rdy,
   output logic          err,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_wmask,
   input  logic [31:0]   mem_rdata,
   output logic          mem_rstrb,
   input  logic          mem_rbusy,
   input  logic          mem_wbusy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STRB = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   logic   req_wen;
   logic   busy;

   // Only the busy line matching the latched direction is watched.
   assign busy = req_wen ? mem_wbusy : mem_rbusy;

`ifdef TCB_FEMTO_BRIDGE_TIMEOUT_EN
   localparam logic [15:0] TMO_LIM = 16'(TMO);
   logic [15:0] cnt;
   logic        err_q;

   assign err = err_q;

   // Request FSM with busy-wait timeout; strobe, ready and error are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_wen   <= 1'b0;
         tcb_rdy   <= 1'b0;
         err_q     <= 1'b0;
         tcb_rdt   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
         cnt       <= '0;
      end else begin
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
         tcb_rdy   <= 1'b0;
         err_q     <= 1'b0;
         case (state)
            IDLE: begin
               if (tcb_vld) begin
                  req_wen   <= tcb_wen;
                  mem_addr  <= 32'(tcb_adr);
                  mem_wdata <= tcb_wdt;
                  // Strobe/mask are raised now so they are visible exactly in STRB.
                  mem_wmask <= tcb_wen ? tcb_ben : 4'b0000;
                  mem_rstrb <= ~tcb_wen;
                  state     <= STRB;
               end
            end
            STRB: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (!busy) begin
                  if (!req_wen) tcb_rdt <= mem_rdata;
                  tcb_rdy <= 1'b1;
                  state   <= DONE;
               end else if (cnt == TMO_LIM) begin
                  if (!req_wen) tcb_rdt <= 32'hdeadbeef;
                  tcb_rdy <= 1'b1;
                  err_q   <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign err = 1'b0;

   // Request FSM without timeout; strobe and ready are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_wen   <= 1'b0;
         tcb_rdy   <= 1'b0;
         tcb_rdt   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
      end else begin
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
         tcb_rdy   <= 1'b0;
         case (state)
            IDLE: begin
               if (tcb_vld) begin
                  req_wen   <= tcb_wen;
                  mem_addr  <= 32'(tcb_adr);
                  mem_wdata <= tcb_wdt;
                  // Strobe/mask are raised now so they are visible exactly in STRB.
                  mem_wmask <= tcb_wen ? tcb_ben : 4'b0000;
                  mem_rstrb <= ~tcb_wen;
                  state     <= STRB;
               end
            end
            STRB: begin
               state <= WAIT;
            end
            WAIT: begin
               if (!busy) begin
                  if (!req_wen) tcb_rdt <= mem_rdata;
                  tcb_rdy <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule
